// File: rtl/abc.sv
`default_nettype none
// ============================================================================
// abc : dual-producer dav_/rfd handshake consumer; emits one pulse of
//       max(x, y) clock periods per captured pair.          Rev 1.0
// ============================================================================
module abc (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav_x,
  input  logic [7:0] x,
  output logic       rfd_x,
  input  logic       dav_y,
  input  logic [7:0] y,
  output logic       rfd_y,
  output logic       out
);

  typedef enum logic [1:0] {
    S_WAIT_DAV = 2'd0,
    S_WAIT_REL = 2'd1,
    S_PULSE    = 2'd2
  } star_t;

  star_t      star_q, star_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] count_q, count_d;
  logic       rfd_x_q, rfd_x_d;
  logic       rfd_y_q, rfd_y_d;
  logic       out_q, out_d;
  logic [7:0] max_xy;

  assign max_xy = (x_q >= y_q) ? x_q : y_q;

  assign rfd_x = rfd_x_q;
  assign rfd_y = rfd_y_q;
  assign out   = out_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      star_q  <= S_WAIT_DAV;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      count_q <= 8'd0;
      rfd_x_q <= 1'b1;
      rfd_y_q <= 1'b1;
      out_q   <= 1'b0;
    end else begin
      star_q  <= star_d;
      x_q     <= x_d;
      y_q     <= y_d;
      count_q <= count_d;
      rfd_x_q <= rfd_x_d;
      rfd_y_q <= rfd_y_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    star_d  = star_q;
    x_d     = x_q;
    y_d     = y_q;
    count_d = count_q;
    rfd_x_d = rfd_x_q;
    rfd_y_d = rfd_y_q;
    out_d   = out_q;
    case (star_q)
      S_WAIT_DAV: begin
        // Operands are captured only when both producers present data together.
        if (!dav_x && !dav_y) begin
          x_d     = x;
          y_d     = y;
          rfd_x_d = 1'b0;
          rfd_y_d = 1'b0;
          star_d  = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (dav_x && dav_y) begin
          count_d = max_xy;
          if (max_xy != 8'd0) begin
            out_d  = 1'b1;
            star_d = S_PULSE;
          end else begin
            rfd_x_d = 1'b1;
            rfd_y_d = 1'b1;
            star_d  = S_WAIT_DAV;
          end
        end
      end
      S_PULSE: begin
        // COUNT holds the remaining high periods including the current one.
        if (count_q == 8'd1) begin
          out_d   = 1'b0;
          rfd_x_d = 1'b1;
          rfd_y_d = 1'b1;
          star_d  = S_WAIT_DAV;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      default: begin
        out_d   = 1'b0;
        rfd_x_d = 1'b1;
        rfd_y_d = 1'b1;
        star_d  = S_WAIT_DAV;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_abc.sv
`default_nettype none
// ============================================================================
// tb_abc : scoreboard bench for abc; producers drive randomized pairs, a
//          monitor measures every pulse against the queued max(x, y). Rev 1.0
// ============================================================================
module tb_abc;

  logic       clock;
  logic       reset;
  logic       dav_x;
  logic [7:0] x;
  logic       rfd_x;
  logic       dav_y;
  logic [7:0] y;
  logic       rfd_y;
  logic       out;

  abc dut (
    .clock (clock),
    .reset (reset),
    .dav_x (dav_x),
    .x     (x),
    .rfd_x (rfd_x),
    .dav_y (dav_y),
    .y     (y),
    .rfd_y (rfd_y),
    .out   (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_pushed = 0;
  int n_flush  = 0;
  int n_pulses = 0;
  int exp_q[$];
  bit flush    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One producer's full handshake: dav_ low, wait rfd low, release dav_.
  task automatic prod(input bit is_y, input logic [7:0] v, input int lead);
    int t;
    repeat (lead) step();
    t = 0;
    while (((is_y ? rfd_y : rfd_x) !== 1'b1) && t < 3000) begin step(); t++; end
    check(is_y ? "y_rfd_ready" : "x_rfd_ready", (t < 3000), 1);
    if (is_y) begin y = v; dav_y = 1'b0; end
    else      begin x = v; dav_x = 1'b0; end
    t = 0;
    while (((is_y ? rfd_y : rfd_x) !== 1'b0) && t < 3000) begin step(); t++; end
    check(is_y ? "y_rfd_capture" : "x_rfd_capture", (t < 3000), 1);
    repeat ($urandom_range(0, 2)) step();
    if (is_y) begin dav_y = 1'b1; y = 8'($urandom); end
    else      begin dav_x = 1'b1; x = 8'($urandom); end
  endtask

  task automatic push_exp(input int a, input int b);
    if (max2(a, b) != 0) begin
      exp_q.push_back(max2(a, b));
      n_pushed++;
    end
  endtask

  task automatic xact(input logic [7:0] a, input logic [7:0] b, input int la, input int lb);
    push_exp(a, b);
    fork
      prod(1'b0, a, la);
      prod(1'b1, b, lb);
    join
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(rfd_x === 1'b1 && rfd_y === 1'b1 && out === 1'b0) && t < 3000) begin step(); t++; end
    check("idle_reached", (t < 3000), 1);
    step();
  endtask

  // Monitor: pulse width, inter-pulse gap, and handshake ordering.
  int   width    = 0;
  int   gap      = 0;
  bit   gap_free = 1'b1;
  logic p_out    = 1'b0;
  logic p_rfd_x  = 1'b1;
  logic p_rfd_y  = 1'b1;
  logic p_dav_x  = 1'b1;
  logic p_dav_y  = 1'b1;

  always @(negedge clock) begin
    if (rfd_x !== p_rfd_x || rfd_y !== p_rfd_y)
      check("rfd_together", {31'd0, rfd_x}, {31'd0, rfd_y});
    if (p_rfd_x === 1'b1 && rfd_x === 1'b0 && !reset)
      check("capture_needs_both_dav", {30'd0, p_dav_x, p_dav_y}, 32'd0);
    if (out === 1'b1) begin
      if (p_out !== 1'b1) begin
        if (!gap_free) check("low_gap_min2", (gap >= 2), 1);
        width = 0;
      end
      width++;
      check("rfd_low_in_pulse", {30'd0, rfd_x, rfd_y}, 32'd0);
    end else begin
      if (p_out === 1'b1) begin
        if (flush) begin
          flush = 1'b0;
          if (exp_q.size() > 0) begin void'(exp_q.pop_front()); n_flush++; end
          gap_free = 1'b1;
        end else if (exp_q.size() == 0) begin
          check("unexpected_pulse", width, 0);
          gap_free = 1'b0;
        end else begin
          check("pulse_width", width, exp_q.pop_front());
          check("rfd_rise_at_out_fall", {30'd0, rfd_x, rfd_y}, 32'd3);
          n_pulses++;
          gap_free = 1'b0;
        end
        gap = 0;
      end
      gap++;
    end
    p_out   = out;
    p_rfd_x = rfd_x;
    p_rfd_y = rfd_y;
    p_dav_x = dav_x;
    p_dav_y = dav_y;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] rx [32];
  logic [7:0] ry [32];

  initial begin
    reset = 1'b1;
    dav_x = 1'b1;
    dav_y = 1'b1;
    x     = 8'd0;
    y     = 8'd0;
    repeat (2) step();
    reset = 1'b0;
    check("reset_state", {29'd0, rfd_x, rfd_y, out}, 32'd6);
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_stable", {29'd0, rfd_x, rfd_y, out}, 32'd6);
    end

    // X presents several cycles ahead of Y.
    xact(8'd15, 8'd5, 0, 6);
    wait_idle();
    xact(8'd5, 8'd12, 1, 0);
    wait_idle();
    xact(8'd20, 8'd20, 0, 0);
    wait_idle();
    xact(8'd1, 8'd1, 2, 1);
    wait_idle();
    xact(8'd255, 8'd0, 0, 3);
    wait_idle();

    // Zero pair: no pulse, rfd back one cycle after release.
    x = 8'd0; y = 8'd0; dav_x = 1'b0; dav_y = 1'b0;
    step();
    check("zero_capture", {30'd0, rfd_x, rfd_y}, 32'd0);
    dav_x = 1'b1; dav_y = 1'b1;
    step();
    check("zero_release", {29'd0, rfd_x, rfd_y, out}, 32'd6);
    repeat (3) step();
    check("zero_no_pulse", {31'd0, out}, 32'd0);

    // 32 back-to-back pairs, X producer running faster than Y.
    for (int i = 0; i < 32; i++) begin
      rx[i] = 8'($urandom_range(0, 40));
      ry[i] = 8'($urandom_range(0, 40));
    end
    fork
      begin
        for (int i = 0; i < 32; i++) prod(1'b0, rx[i], $urandom_range(0, 1));
      end
      begin
        for (int j = 0; j < 32; j++) begin
          push_exp(rx[j], ry[j]);
          prod(1'b1, ry[j], $urandom_range(2, 4));
        end
      end
    join
    wait_idle();

    // Reset in the middle of a 30-cycle pulse.
    xact(8'd30, 8'd3, 0, 0);
    begin
      int t;
      t = 0;
      while (out !== 1'b1 && t < 3000) begin step(); t++; end
      check("midpulse_started", (t < 3000), 1);
    end
    repeat (9) step();
    flush = 1'b1;
    reset = 1'b1;
    step();
    check("midpulse_reset", {29'd0, rfd_x, rfd_y, out}, 32'd6);
    reset = 1'b0;
    step();
    xact(8'd7, 8'd9, 1, 0);
    wait_idle();

    check("scoreboard_empty", exp_q.size(), 0);
    check("pulse_count", n_pulses, n_pushed - n_flush);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
